// File: rtl/bus_grant_sched.sv
// bus_grant_sched: three-way round-robin scheduler for the shared DSP memory bus.
// Requesters are numbered 1=DMA, 2=TDSP, 3=host. That number is also the mux
// select placed on 'owner'; 0 means no owner.
// Each tenure is bounded when another requester is waiting. A dead turnaround
// gap separates consecutive owners.
// Ports:
//   clk, reset (async, active low)
//   dma_breq/tdsp_breq/host_breq  : level requests, held until done
//   dma_grant/tdsp_grant/host_grant: registered, mutually exclusive grants
//   owner    : registered mux select, consistent with the grants
//   bus_busy : registered, high while any grant is high
//   preempt  : one-cycle pulse in the cycle a grant is revoked on expiry
module bus_grant_sched #(
   parameter int MAX_TENURE  = 16,  // 2..255
   parameter int TURN_CYCLES = 1    // 1..4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dma_breq,
   input  logic       tdsp_breq,
   input  logic       host_breq,
   output logic       dma_grant,
   output logic       tdsp_grant,
   output logic       host_grant,
   output logic [1:0] owner,
   output logic       bus_busy,
   output logic       preempt
);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

   localparam logic [7:0] CNT_LAST  = 8'(MAX_TENURE - 1);
   localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] tcnt_q, tcnt_d;
   logic [1:0] last_q, last_d;
   logic [1:0] owner_q, owner_d;
   logic [2:0] grant_q, grant_d;   // {host, tdsp, dma}
   logic       busy_q, busy_d;
   logic       preempt_q, preempt_d;

   // Bit 0 is tied low so that an index of 0 (no owner) reads as "not requesting".
   logic [3:0] req;
   logic [1:0] c1, c2, c3, winner;
   logic       others_req;

   assign req = {host_breq, tdsp_breq, dma_breq, 1'b0};

   function automatic logic [1:0] next_id(input logic [1:0] id);
      return (id == 2'd3) ? 2'd1 : id + 2'd1;
   endfunction

   // Round-robin search starts at the requester after the last owner.
   always_comb begin
      c1     = next_id(last_q);
      c2     = next_id(c1);
      c3     = next_id(c2);
      winner = 2'd0;
      if (req[c1])      winner = c1;
      else if (req[c2]) winner = c2;
      else if (req[c3]) winner = c3;
   end

   assign others_req = |(req & ~(4'b0001 << owner_q));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tcnt_d    = tcnt_q;
      last_d    = last_q;
      owner_d   = owner_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (winner != 2'd0) begin
               owner_d = winner;
               last_d  = winner;
               cnt_d   = 8'd0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // A release on the expiry edge is a normal release, so it is tested first.
            if (!req[owner_q]) begin
               owner_d = 2'd0;
               tcnt_d  = 3'd0;
               state_d = TURN;
            end else if (cnt_q == CNT_LAST && others_req) begin
               owner_d   = 2'd0;
               preempt_d = 1'b1;
               tcnt_d    = 3'd0;
               state_d   = TURN;
            end else if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         TURN: begin
            if (tcnt_q == TURN_LAST) state_d = IDLE;
            else                     tcnt_d  = tcnt_q + 3'd1;
         end
         default: begin
            owner_d = 2'd0;
            state_d = IDLE;
         end
      endcase
      grant_d = {owner_d == 2'd3, owner_d == 2'd2, owner_d == 2'd1};
      busy_d  = (owner_d != 2'd0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         tcnt_q    <= 3'd0;
         last_q    <= 2'd3;
         owner_q   <= 2'd0;
         grant_q   <= 3'b000;
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tcnt_q    <= tcnt_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         preempt_q <= preempt_d;
      end
   end

   assign dma_grant  = grant_q[0];
   assign tdsp_grant = grant_q[1];
   assign host_grant = grant_q[2];
   assign owner      = owner_q;
   assign bus_busy   = busy_q;
   assign preempt    = preempt_q;

endmodule

// File: tb/tb_bus_grant_sched.sv
// Bench for bus_grant_sched. A behavioural model tracks the current owner, how
// many cycles it has held the bus, and how many edges remain before arbitration
// reopens. Outputs are compared with the model on every falling edge.
module tb_bus_grant_sched;
   localparam int MAX_T = 4;
   localparam int TURN  = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       dma_breq = 1'b0, tdsp_breq = 1'b0, host_breq = 1'b0;
   logic       dma_grant, tdsp_grant, host_grant, bus_busy, preempt;
   logic [1:0] owner;

   int checks = 0;
   int errors = 0;

   // model state: owner id (0 none), cycles held, edges until arbitration, last owner
   int m_cur, m_age, m_wait, m_last;
   bit m_pre;

   bus_grant_sched #(.MAX_TENURE(MAX_T), .TURN_CYCLES(TURN)) dut (
      .clk(clk), .reset(reset),
      .dma_breq(dma_breq), .dma_grant(dma_grant),
      .tdsp_breq(tdsp_breq), .tdsp_grant(tdsp_grant),
      .host_breq(host_breq), .host_grant(host_grant),
      .owner(owner), .bus_busy(bus_busy), .preempt(preempt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_cur = 0; m_age = 0; m_wait = 0; m_last = 3; m_pre = 0;
   endtask

   task automatic model_release();
      m_cur  = 0;
      m_wait = TURN + 1;
   endtask

   task automatic model_step();
      logic [3:0] r;
      bit found;
      int c;
      r = {host_breq, tdsp_breq, dma_breq, 1'b0};
      if (!reset) begin
         model_reset();
      end else begin
         m_pre = 0;
         if (m_cur != 0) begin
            m_age++;
            if (!r[m_cur]) model_release();
            else if (m_age >= MAX_T && (r & ~(4'b0001 << m_cur)) != 4'b0000) begin
               model_release();
               m_pre = 1;
            end
         end else if (m_wait > 1) begin
            m_wait--;
         end else begin
            m_wait = 0;
            found  = 0;
            c      = m_last;
            for (int k = 0; k < 3; k++) begin
               c = (c % 3) + 1;
               if (!found && r[c]) begin
                  found  = 1;
                  m_cur  = c;
                  m_last = c;
                  m_age  = 0;
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("dma_grant",  {1'b0, dma_grant},  {1'b0, m_cur == 1});
      chk("tdsp_grant", {1'b0, tdsp_grant}, {1'b0, m_cur == 2});
      chk("host_grant", {1'b0, host_grant}, {1'b0, m_cur == 3});
      chk("owner",      owner,              2'(m_cur));
      chk("bus_busy",   {1'b0, bus_busy},   {1'b0, m_cur != 0});
      chk("preempt",    {1'b0, preempt},    {1'b0, m_pre});
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_req(input logic d, input logic t, input logic h);
      dma_breq = d; tdsp_breq = t; host_breq = h;
   endtask

   initial begin
      model_reset();
      // Reset hold with every request asserted
      set_req(1, 1, 1);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("first_grant_dma", {1'b0, dma_grant}, 2'd1);
      chk("first_owner", owner, 2'd1);

      // Let the bus drain, then a single 4-cycle DMA request
      set_req(0, 0, 0);
      repeat (6) tick();
      dma_breq = 1'b1;
      repeat (4) tick();
      dma_breq = 1'b0;
      repeat (4) tick();

      // Round robin with every requester held high
      set_req(1, 1, 1);
      repeat (30) tick();
      set_req(0, 0, 0);
      repeat (6) tick();

      // Lone owner keeps the bus with no preempt
      tdsp_breq = 1'b1;
      repeat (40) tick();
      chk("lone_owner_held", {1'b0, tdsp_grant}, 2'd1);
      tdsp_breq = 1'b0;
      repeat (6) tick();

      // Owner releases on the expiry edge while host waits
      tdsp_breq = 1'b1;
      tick();
      host_breq = 1'b1;
      repeat (3) tick();
      tdsp_breq = 1'b0;
      tick();
      chk("same_edge_no_preempt", {1'b0, preempt}, 2'd0);
      repeat (4) tick();
      chk("host_after_turn", {1'b0, host_grant}, 2'd1);
      host_breq = 1'b0;
      repeat (6) tick();

      // Randomized request traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) dma_breq  = ~dma_breq;
         if ($urandom_range(0, 3) == 0) tdsp_breq = ~tdsp_breq;
         if ($urandom_range(0, 3) == 0) host_breq = ~host_breq;
         tick();
      end
      set_req(0, 0, 0);
      repeat (8) tick();

      // Asynchronous reset during a host tenure
      host_breq = 1'b1;
      repeat (3) tick();
      chk("host_before_reset", {1'b0, host_grant}, 2'd1);
      #2 reset = 1'b0;
      model_reset();
      #1 check_outputs();
      chk("async_drop", {1'b0, host_grant}, 2'd0);
      tick();
      set_req(1, 1, 1);
      reset = 1'b1;
      tick();
      chk("restart_at_dma", owner, 2'd1);
      repeat (10) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
